// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the instruction fetch/sequencing stage:
//   - PC mode encodings driven onto the program counter's mode input
//   - control-flow opcodes decoded from the instruction's top nibble
//   - fetch FSM state encoding
// -----------------------------------------------------------------------------
package fetch_pkg;

    // Program counter mode encodings
    localparam logic [1:0] PC_STEP = 2'b00;  // pc <= pc + 1
    localparam logic [1:0] PC_LOAD = 2'b01;  // pc <= data (also used to hold)
    localparam logic [1:0] PC_POP  = 2'b10;  // pc <= return stack top
    localparam logic [1:0] PC_PUSH = 2'b11;  // push pc + 1, pc <= data

    // Control-flow opcodes (instruction bits [INSTR_W-1 -: 4])
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_BNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Fetch FSM states
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_branch_resolve.sv
// -----------------------------------------------------------------------------
// fetch_branch_resolve
// Purely combinational opcode resolver. Given the issued instruction's opcode
// and target, the ALU zero flag and the current PC, it produces the PC mode and
// data to apply on the handshake cycle plus HALT/CALL/RET classification.
// Ports:
//   opcode    in  4       instruction opcode nibble
//   target    in  ADDR_W  jump/call/branch target
//   zero_flag in  1       ALU zero flag
//   pc_value  in  ADDR_W  current PC (data for non-load modes)
//   mode      out 2       resolved PC mode
//   data      out ADDR_W  resolved PC data
//   is_halt   out 1       opcode is HALT
//   is_call   out 1       opcode is CALL
//   is_ret    out 1       opcode is RET
// -----------------------------------------------------------------------------
module fetch_branch_resolve
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] target,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] pc_value,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] data,
    output logic              is_halt,
    output logic              is_call,
    output logic              is_ret
);

    // Opcode to PC-control decode; anything not listed simply steps.
    always_comb begin
        mode    = PC_STEP;
        data    = pc_value;
        is_halt = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        case (opcode)
            OP_JMP: begin
                mode = PC_LOAD;
                data = target;
            end
            OP_CALL: begin
                mode    = PC_PUSH;
                data    = target;
                is_call = 1'b1;
            end
            OP_RET: begin
                mode   = PC_POP;
                is_ret = 1'b1;
            end
            OP_BZ: begin
                if (zero_flag) begin
                    mode = PC_LOAD;
                    data = target;
                end else begin
                    mode = PC_STEP;
                end
            end
            OP_BNZ: begin
                if (!zero_flag) begin
                    mode = PC_LOAD;
                    data = target;
                end else begin
                    mode = PC_STEP;
                end
            end
            OP_HALT: begin
                // HALT still steps once so the PC parks just past it
                mode    = PC_STEP;
                is_halt = 1'b1;
            end
            default: begin
                mode = PC_STEP;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Fetch/sequencing stage sitting after the program counter. Each instruction
// takes FETCH (address ROM) -> LATCH (capture ROM word) -> ISSUE (valid/ready
// to decoder). The PC has no enable, so it is stalled by loading its own value.
// On the handshake the opcode decides step/jump/call/return/halt.
//
// Optional feature macro: FETCH_STACK_GUARD_EN
//   Defined   : tracks call depth and turns stack over/underflow into a hold,
//               setting stack_err and halting.
//   Undefined : CALL/RET always executed, stack_err tied low.
//
// Ports:
//   clk         in  1        rising-edge clock
//   rst         in  1        asynchronous active-high reset
//   pc_value    in  ADDR_W   current PC
//   pc_mode     out 2        PC mode (00 step, 01 load, 10 pop, 11 push+load)
//   pc_data     out ADDR_W   PC load data
//   rom_addr    out ADDR_W   program ROM address
//   rom_data    in  INSTR_W  program ROM data (one cycle after address)
//   instr_o     out INSTR_W  latched instruction
//   instr_pc    out ADDR_W   address of instr_o
//   instr_valid out 1        instruction offered to decoder
//   instr_ready in  1        decoder accepts
//   zero_flag   in  1        ALU zero flag, used on handshake
//   halted      out 1        sticky halt indication
//   stack_err   out 1        sticky stack over/underflow indication
// -----------------------------------------------------------------------------
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_value,
    output logic [1:0]         pc_mode,
    output logic [ADDR_W-1:0]  pc_data,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               zero_flag,
    output logic               halted,
    output logic               stack_err
);

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               halted_q, halted_d;

    logic [1:0]         br_mode;
    logic [ADDR_W-1:0]  br_data;
    logic               br_is_halt;
    logic               br_is_call;
    logic               br_is_ret;
    logic               issue_hs;
    logic               guard_viol;

    fetch_branch_resolve #(
        .ADDR_W (ADDR_W)
    ) u_resolve (
        .opcode    (instr_q[INSTR_W-1 -: 4]),
        .target    (instr_q[ADDR_W-1:0]),
        .zero_flag (zero_flag),
        .pc_value  (pc_value),
        .mode      (br_mode),
        .data      (br_data),
        .is_halt   (br_is_halt),
        .is_call   (br_is_call),
        .is_ret    (br_is_ret)
    );

    assign issue_hs    = (state_q == ST_ISSUE) && instr_ready;
    // The ROM is always addressed by the PC; its data is only used in LATCH
    assign rom_addr    = pc_value;
    assign instr_o     = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign halted      = halted_q;

`ifdef FETCH_STACK_GUARD_EN
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               stack_err_q, stack_err_d;

    // A CALL into a full stack or a RET from an empty one is never executed
    assign guard_viol = (br_is_call && (depth_q == DEPTH_MAX)) ||
                        (br_is_ret  && (depth_q == {DEPTH_W{1'b0}}));
    assign stack_err  = stack_err_q;

    // Call-depth tracking: only executed CALL/RET move the counter
    always_comb begin
        depth_d     = depth_q;
        stack_err_d = stack_err_q;
        if (issue_hs) begin
            if (guard_viol) begin
                stack_err_d = 1'b1;
            end else if (br_is_call) begin
                depth_d = depth_q + DEPTH_W'(1);
            end else if (br_is_ret) begin
                depth_d = depth_q - DEPTH_W'(1);
            end else begin
                depth_d = depth_q;
            end
        end else begin
            depth_d = depth_q;
        end
    end

    // Call-depth and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q     <= {DEPTH_W{1'b0}};
            stack_err_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            stack_err_q <= stack_err_d;
        end
    end
`else
    localparam int unused_stack_depth = STACK_DEPTH;
    logic unused_stack_ops;

    assign unused_stack_ops = br_is_call ^ br_is_ret;
    assign guard_viol       = 1'b0;
    assign stack_err        = 1'b0;
`endif

    // Fetch FSM next state and PC control; the PC is held unless an
    // instruction completes its handshake.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        halted_d   = halted_q;
        pc_mode    = PC_LOAD;
        pc_data    = pc_value;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                instr_d    = rom_data;
                instr_pc_d = pc_value;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    if (guard_viol) begin
                        // Hold the PC and stop: the stack can no longer be trusted
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_mode = br_mode;
                        pc_data = br_data;
                        if (br_is_halt) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // FSM state and instruction/status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            instr_q    <= {INSTR_W{1'b0}};
            instr_pc_q <= {ADDR_W{1'b0}};
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            halted_q   <= halted_d;
        end
    end

endmodule
